// File: rtl/seq_div.sv
// seq_div: sequential restoring unsigned divider, K = N/CC quotient bits per cycle.
// Ports: clk, rst (async, active-high), start, dividend, divisor in;
//   busy, done, quotient, remainder, div_by_zero out.
module seq_div #(
  parameter int N  = 32,
  parameter int CC = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int K  = N / CC;
  localparam int CW = $clog2(CC + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;

  logic [1:0]    state;
  logic [CW-1:0] ctr;
  logic [N-1:0]  r;
  logic [N-1:0]  q;
  logic [N-1:0]  d;
  logic          dz;

  logic [N-1:0]  r_nx;
  logic [N-1:0]  q_nx;
  logic [N:0]    t;
  logic [N:0]    diff;

  // K restoring steps chained in one cycle, MSB first.
  // The trial value is N+1 bits so the compare never overflows.
  always_comb begin
    r_nx = r;
    q_nx = q;
    t    = '0;
    diff = '0;
    for (int i = 0; i < K; i++) begin
      t    = {r_nx, q_nx[N-1]};
      q_nx = {q_nx[N-2:0], 1'b0};
      diff = t - {1'b0, d};
      if (t >= {1'b0, d}) begin
        r_nx    = diff[N-1:0];
        q_nx[0] = 1'b1;
      end else begin
        r_nx = t[N-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ctr   <= '0;
      r     <= '0;
      q     <= '0;
      d     <= '0;
      dz    <= 1'b0;
    end else begin
      unique case (state)
        IDLE, FIN: begin
          // FIN accepts start too, giving back-to-back operation.
          if (start) begin
            d     <= divisor;
            r     <= '0;
            q     <= dividend;
            dz    <= (divisor == '0);
            ctr   <= CW'(CC);
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          r   <= r_nx;
          q   <= q_nx;
          ctr <= ctr - CW'(1);
          if (ctr == CW'(1)) begin
            state <= FIN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // All outputs decode registers only; no input-to-output path.
  assign busy        = (state == RUN);
  assign done        = (state == FIN);
  assign quotient    = q;
  assign remainder   = r;
  assign div_by_zero = dz;

endmodule

// File: tb/tb_seq_div.sv
// tb_seq_div: directed and random checks of seq_div on six N/CC configurations.
// Reference results come from plain integer division in the bench.
module tb_seq_div;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  // index: 0 N8/CC8, 1 N8/CC2, 2 N8/CC4, 3 N32/CC1, 4 N32/CC4, 5 N32/CC32
  logic [5:0]       st;
  logic [5:0][31:0] dvd;
  logic [5:0][31:0] dvs;
  wire  [5:0]       bs;
  wire  [5:0]       dn;
  wire  [5:0]       dz;
  wire  [5:0][31:0] qo;
  wire  [5:0][31:0] ro;
  wire  [2:0][7:0]  q8;
  wire  [2:0][7:0]  r8;

  int checks   = 0;
  int failures = 0;

  assign qo[0] = {24'h0, q8[0]};
  assign qo[1] = {24'h0, q8[1]};
  assign qo[2] = {24'h0, q8[2]};
  assign ro[0] = {24'h0, r8[0]};
  assign ro[1] = {24'h0, r8[1]};
  assign ro[2] = {24'h0, r8[2]};

  seq_div #(.N(8), .CC(8)) u0 (
    .clk(clk), .rst(rst), .start(st[0]),
    .dividend(dvd[0][7:0]), .divisor(dvs[0][7:0]),
    .busy(bs[0]), .done(dn[0]), .quotient(q8[0]),
    .remainder(r8[0]), .div_by_zero(dz[0])
  );

  seq_div #(.N(8), .CC(2)) u1 (
    .clk(clk), .rst(rst), .start(st[1]),
    .dividend(dvd[1][7:0]), .divisor(dvs[1][7:0]),
    .busy(bs[1]), .done(dn[1]), .quotient(q8[1]),
    .remainder(r8[1]), .div_by_zero(dz[1])
  );

  seq_div #(.N(8), .CC(4)) u2 (
    .clk(clk), .rst(rst), .start(st[2]),
    .dividend(dvd[2][7:0]), .divisor(dvs[2][7:0]),
    .busy(bs[2]), .done(dn[2]), .quotient(q8[2]),
    .remainder(r8[2]), .div_by_zero(dz[2])
  );

  seq_div #(.N(32), .CC(1)) u3 (
    .clk(clk), .rst(rst), .start(st[3]),
    .dividend(dvd[3]), .divisor(dvs[3]),
    .busy(bs[3]), .done(dn[3]), .quotient(qo[3]),
    .remainder(ro[3]), .div_by_zero(dz[3])
  );

  seq_div #(.N(32), .CC(4)) u4 (
    .clk(clk), .rst(rst), .start(st[4]),
    .dividend(dvd[4]), .divisor(dvs[4]),
    .busy(bs[4]), .done(dn[4]), .quotient(qo[4]),
    .remainder(ro[4]), .div_by_zero(dz[4])
  );

  seq_div #(.N(32), .CC(32)) u5 (
    .clk(clk), .rst(rst), .start(st[5]),
    .dividend(dvd[5]), .divisor(dvs[5]),
    .busy(bs[5]), .done(dn[5]), .quotient(qo[5]),
    .remainder(ro[5]), .div_by_zero(dz[5])
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      $error("check %s", tag);
    end
  endtask

  function automatic logic [31:0] mk(input int n);
    logic [31:0] one;
    one = 32'd1;
    return (n == 32) ? 32'hFFFF_FFFF : ((one << n) - 32'd1);
  endfunction

  // Reference: floor division; divide by zero gives all ones / dividend.
  task automatic model(input int n, input logic [31:0] a,
                       input logic [31:0] b, output logic [31:0] eq,
                       output logic [31:0] er);
    if (b == 32'd0) begin
      eq = mk(n);
      er = a;
    end else begin
      eq = a / b;
      er = a % b;
    end
  endtask

  task automatic idle(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Runs one division; returns in the cycle where done is expected,
  // so a following call starts back-to-back from FIN.
  task automatic run_div(input int i, input int cc, input int n,
                         input logic [31:0] a0, input logic [31:0] b0,
                         input bit glitch);
    logic [31:0] a, b, eq, er;
    int lat;
    a = a0 & mk(n);
    b = b0 & mk(n);
    model(n, a, b, eq, er);
    dvd[i] = a;
    dvs[i] = b;
    st[i]  = 1'b1;
    @(posedge clk);
    #1;
    st[i]  = 1'b0;
    dvd[i] = $urandom;
    dvs[i] = $urandom;
    chk("busy_e0", 32'(bs[i]), 32'd1);
    lat = 0;
    while (lat < cc + 2) begin
      st[i] = glitch && (lat == 2);
      @(posedge clk);
      #1;
      lat++;
      if (dn[i] === 1'b1) break;
      chk("busy_run", 32'(bs[i]), 32'd1);
    end
    st[i] = 1'b0;
    chk("latency", 32'(lat), 32'(cc));
    chk("done", 32'(dn[i]), 32'd1);
    chk("busy_fin", 32'(bs[i]), 32'd0);
    chk("quot", qo[i], eq);
    chk("rem", ro[i], er);
    chk("dz", 32'(dz[i]), 32'(b == 32'd0));
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 255));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] a, b, eq, er;
    int n_done;
    int lat;
    st  = '0;
    dvd = '0;
    dvs = '0;
    idle(2);
    for (int i = 0; i < 6; i++) begin
      chk("rst_busy", 32'(bs[i]), 32'd0);
      chk("rst_done", 32'(dn[i]), 32'd0);
      chk("rst_q", qo[i], 32'd0);
      chk("rst_r", ro[i], 32'd0);
      chk("rst_dz", 32'(dz[i]), 32'd0);
    end
    rst = 1'b0;
    idle(2);

    run_div(0, 8, 8, 32'd100, 32'd7, 1'b0);
    chk("d100_7_q", qo[0], 32'd14);
    chk("d100_7_r", ro[0], 32'd2);
    idle(3);
    chk("hold_q", qo[0], 32'd14);
    chk("hold_r", ro[0], 32'd2);

    run_div(1, 2, 8, 32'd255, 32'd16, 1'b0);
    chk("d255_16_q", qo[1], 32'd15);
    run_div(1, 2, 8, 32'd5, 32'd9, 1'b0);
    chk("d5_9_r", ro[1], 32'd5);

    run_div(2, 4, 8, 32'hA5, 32'd0, 1'b0);
    chk("dz_q", qo[2], 32'hFF);
    chk("dz_r", ro[2], 32'hA5);
    chk("dz_flag", 32'(dz[2]), 32'd1);
    idle(1);
    run_div(2, 4, 8, 32'd200, 32'd200, 1'b0);
    chk("d200_q", qo[2], 32'd1);
    chk("d200_dz", 32'(dz[2]), 32'd0);
    idle(1);

    // start held high; operands only valid on accept cycles.
    st[0] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      a = 32'($urandom_range(0, 255));
      b = 32'($urandom_range(1, 255));
      model(8, a, b, eq, er);
      dvd[0] = a;
      dvs[0] = b;
      @(posedge clk);
      #1;
      dvd[0] = $urandom;
      dvs[0] = $urandom;
      chk("hh_nodone", 32'(dn[0]), 32'd0);
      lat = 0;
      while (lat < 12) begin
        @(posedge clk);
        #1;
        lat++;
        if (dn[0] === 1'b1) break;
      end
      chk("hh_lat", 32'(lat), 32'd8);
      chk("hh_q", qo[0], eq);
      chk("hh_r", ro[0], er);
    end
    st[0] = 1'b0;
    idle(1);

    run_div(0, 8, 8, 32'd143, 32'd11, 1'b1);
    idle(2);

    // Asynchronous reset in the third RUN cycle.
    dvd[0] = 32'd200;
    dvs[0] = 32'd7;
    st[0]  = 1'b1;
    idle(1);
    st[0]  = 1'b0;
    idle(2);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_busy", 32'(bs[0]), 32'd0);
    chk("arst_done", 32'(dn[0]), 32'd0);
    chk("arst_q", qo[0], 32'd0);
    chk("arst_r", ro[0], 32'd0);
    chk("arst_dz", 32'(dz[0]), 32'd0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    n_done = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (dn[0] === 1'b1) n_done++;
    end
    chk("arst_nodone", 32'(n_done), 32'd0);
    run_div(0, 8, 8, 32'd50, 32'd3, 1'b0);
    chk("d50_3_q", qo[0], 32'd16);
    chk("d50_3_r", ro[0], 32'd2);
    idle(1);

    for (int k = 0; k < 2000; k++) begin
      run_div(3, 1, 32, pick(), pick(), 1'b0);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    idle(1);
    for (int k = 0; k < 2000; k++) begin
      run_div(4, 4, 32, pick(), pick(), 1'b0);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    idle(1);
    for (int k = 0; k < 800; k++) begin
      run_div(5, 32, 32, pick(), pick(), 1'b0);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
